// File: rtl/rat_io_pkg.sv
// Shared definitions for RAT MCU port-mapped I/O peripherals.
// Contents: register offsets, CTRL/STATUS bit positions, timer FSM states.
package rat_io_pkg;

  localparam logic [2:0] OFS_CTRL      = 3'd0;
  localparam logic [2:0] OFS_RELOAD_LO = 3'd1;
  localparam logic [2:0] OFS_RELOAD_HI = 3'd2;
  localparam logic [2:0] OFS_STATUS    = 3'd3;
  localparam logic [2:0] OFS_SNAP_LO   = 3'd4;
  localparam logic [2:0] OFS_SNAP_HI   = 3'd5;
  localparam logic [2:0] OFS_PRESCALE  = 3'd6;

  // Number of mapped offsets starting at the base ID
  localparam logic [7:0] NUM_OFS = 8'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_AUTO   = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_PEND    = 0;
  localparam int STAT_RUNNING = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider for rat_timer_io.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset
//   load_i - timer is in its load cycle: pre <= P
//   run_i  - timer is counting
//   p_i    - prescale value P
//   tick_o - one-cycle pulse when pre==0 while running (count step / expiry test)
module timer_prescaler (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       run_i,
  input  logic [7:0] p_i,
  output logic       tick_o
);

  logic [7:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (load_i)
      pre_d = p_i;
    else if (run_i)
      pre_d = (pre_q == 8'd0) ? p_i : pre_q - 8'd1;
  end

  assign tick_o = run_i && (pre_q == 8'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) pre_q <= 8'd0;
    else       pre_q <= pre_d;
  end

endmodule

// File: rtl/rat_timer_io.sv
// Port-mapped 16-bit interval timer on the RAT MCU IN/OUT bus.
// Ports:
//   CLK      - clock
//   RESET    - synchronous active-high reset
//   PORT_ID  - I/O port address from CPU
//   OUT_PORT - write data from CPU
//   IO_STRB  - one-cycle write strobe
//   IN_PORT  - combinational read data, 0 for unmapped IDs
//   INT      - interrupt request (PEND & IRQ_EN), level-held
module rat_timer_io
  import rat_io_pkg::*;
#(
  parameter logic [7:0] BASE_ID = 8'hB0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] PORT_ID,
  input  logic [7:0] OUT_PORT,
  input  logic       IO_STRB,
  output logic [7:0] IN_PORT,
  output logic       INT
);

  timer_state_t state_q, state_d;
  logic [2:0]   ctrl_q, ctrl_d;
  logic [15:0]  reload_q, reload_d;
  logic [7:0]   presc_q, presc_d;
  logic         pend_q, pend_d;
  logic [15:0]  snap_q, snap_d;
  logic [15:0]  count_q, count_d;

  logic is_load, is_run, running, tick, expire;

  // Address decode; the 8-bit difference also rejects IDs below the base
  logic [7:0] ofs_full;
  logic       hit;
  logic [2:0] ofs;
  assign ofs_full = PORT_ID - BASE_ID;
  assign hit      = ofs_full < NUM_OFS;
  assign ofs      = ofs_full[2:0];

  logic wr, wr_ctrl;
  assign wr      = IO_STRB && hit;
  assign wr_ctrl = wr && (ofs == OFS_CTRL);

  timer_prescaler u_presc (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .load_i (is_load),
    .run_i  (is_run),
    .p_i    (presc_q),
    .tick_o (tick)
  );

  // No decrement at zero: a tick at count 0 is the expiry itself
  assign expire = tick && (count_q == 16'd0);

  // FSM: state register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (wr_ctrl && OUT_PORT[CTRL_EN]) state_d = ST_LOAD;
      ST_LOAD:          state_d = ST_RUN;
      ST_RUN:           if (expire) state_d = ctrl_q[CTRL_AUTO] ? ST_LOAD : ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    // Disable beats everything, including a same-cycle expiry
    if (wr_ctrl && !OUT_PORT[CTRL_EN]) state_d = ST_IDLE;
  end

  // FSM: outputs
  always_comb begin
    is_load = (state_q == ST_LOAD);
    is_run  = (state_q == ST_RUN);
    running = is_load || is_run;
  end

  // Register file and counter next state
  always_comb begin
    ctrl_d   = ctrl_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    snap_d   = snap_q;
    pend_d   = pend_q;
    count_d  = count_q;

    if (wr) begin
      unique case (ofs)
        OFS_CTRL:      ctrl_d          = OUT_PORT[2:0];
        OFS_RELOAD_LO: reload_d[7:0]   = OUT_PORT;
        OFS_RELOAD_HI: reload_d[15:8]  = OUT_PORT;
        OFS_SNAP_LO:   snap_d          = count_q;
        OFS_PRESCALE:  presc_d         = OUT_PORT;
        default: ;
      endcase
    end

    // Expiry set has priority over write-1-to-clear
    if (expire)
      pend_d = 1'b1;
    else if (wr && (ofs == OFS_STATUS) && OUT_PORT[STAT_PEND])
      pend_d = 1'b0;

    if (is_load)
      count_d = reload_q;
    else if (tick && (count_q != 16'd0))
      count_d = count_q - 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl_q   <= 3'd0;
      reload_q <= 16'd0;
      presc_q  <= 8'd0;
      snap_q   <= 16'd0;
      pend_q   <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      snap_q   <= snap_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
    end
  end

  // Read mux, zero latency
  always_comb begin
    IN_PORT = 8'h00;
    if (hit) begin
      unique case (ofs)
        OFS_CTRL:      IN_PORT = {5'd0, ctrl_q};
        OFS_RELOAD_LO: IN_PORT = reload_q[7:0];
        OFS_RELOAD_HI: IN_PORT = reload_q[15:8];
        OFS_STATUS:    IN_PORT = {6'd0, running, pend_q};
        OFS_SNAP_LO:   IN_PORT = snap_q[7:0];
        OFS_SNAP_HI:   IN_PORT = snap_q[15:8];
        OFS_PRESCALE:  IN_PORT = presc_q;
        default:       IN_PORT = 8'h00;
      endcase
    end
  end

  assign INT = pend_q && ctrl_q[CTRL_IRQ_EN];

endmodule

// File: doc/rat_timer_io.md
# rat_timer_io

Port-mapped 16-bit interval timer for the RAT MCU I/O bus: the responder end of the CPU's IN/OUT port protocol. It decodes `PORT_ID` and captures `OUT_PORT` on `IO_STRB` for writes. It drives `IN_PORT` combinationally for reads. It raises `INT` toward the control unit on terminal count. It sits beside the other I/O peripherals on the MCU top level; its `IN_PORT` is ORed into the CPU input mux.

## Interface
- `BASE_ID`, default 8'hB0: port ID of offset 0; the block occupies `BASE_ID`..`BASE_ID+6`.
- `CLK` in 1: single clock; all state changes on rising edge.
- `RESET` in 1: synchronous, active-high; one clock clears all state.
- `PORT_ID` in 8: I/O port address from CPU.
- `OUT_PORT` in 8: write data from CPU.
- `IO_STRB` in 1: one-cycle write strobe. Writes take effect at the edge ending the strobe cycle.
- `IN_PORT` out 8: read data, combinational from `PORT_ID` and registers. 8'h00 when `PORT_ID` is unmapped.
- `INT` out 1: interrupt request, equal to `PEND & IRQ_EN`, both registered. Level-held until cleared.

## Operation
- Register map, as offsets from `BASE_ID`:
  - +0 `CTRL`, R/W: bit0 `EN`, bit1 `AUTO_RELOAD`, bit2 `IRQ_EN`. Bits 7:3 read 0.
  - +1 `RELOAD_LO`, R/W.
  - +2 `RELOAD_HI`, R/W.
  - +3 `STATUS`: bit0 `PEND` (write-1-to-clear), bit1 `RUNNING` (read-only, 1 in `ST_LOAD`/`ST_RUN`).
  - +4 `SNAP_LO`: any write copies the live 16-bit count into `SNAP`. Reads return `SNAP[7:0]`.
  - +5 `SNAP_HI`, read-only: returns `SNAP[15:8]`.
  - +6 `PRESCALE`, R/W, value P.
- Writes to unmapped IDs and to read-only offsets are ignored.
- FSM states: `ST_IDLE`, `ST_LOAD`, `ST_RUN`, `ST_DONE`.
  - `ST_IDLE`: counter frozen. A `CTRL` write with `EN`=1 goes to `ST_LOAD`.
  - `ST_LOAD`, one cycle: `count` ← R = {RELOAD_HI, RELOAD_LO}, `pre` ← P, then `ST_RUN`.
  - `ST_RUN`, each cycle:
    - If `pre`==0: `pre` ← P. Then if `count`==0 this is expiry, else `count` ← `count`-1.
    - Otherwise `pre` ← `pre`-1.
    - On expiry: `PEND` ← 1. Next state is `ST_LOAD` if `AUTO_RELOAD`, else `ST_DONE`.
  - `ST_DONE`: count holds 0. A `CTRL` write with `EN`=1 goes to `ST_LOAD`.
  - Any `CTRL` write with `EN`=0 goes to `ST_IDLE` from every state. Count holds its value.
- A `CTRL` write with `EN`=1 while in `ST_LOAD`/`ST_RUN` only updates `AUTO_RELOAD`/`IRQ_EN`. It does not restart the count.
- `RELOAD`/`PRESCALE` writes during `ST_RUN` take effect at the next `ST_LOAD`.
- Arithmetic: unsigned; `count` 16 bits, `pre` 8 bits. There is no wrap: decrement never occurs at 0.

## Timing
- Reset values: all registers 0, `count`=0, `pre`=0, `SNAP`=0, state `ST_IDLE`.
  - `INT`=0 and `IN_PORT`=0 for every `PORT_ID`.
- Enable-to-expiry: with the `EN` write at edge 0, `ST_LOAD` is cycle 1 and `ST_RUN` starts at cycle 2. Expiry is the (R+1)(P+1)-th `ST_RUN` cycle.
- `PEND` and `INT` rise at the edge ending the expiry cycle.
- Auto-reload period is (R+1)(P+1)+1 cycles, because `ST_LOAD` adds one cycle.
- R=0, P=0: expiry on the first `ST_RUN` cycle; auto-reload period is 2.
- Simultaneous `STATUS` W1C and expiry in the same cycle: the set wins and `PEND` stays 1.
- `EN`=0 write in the expiry cycle: the write wins and the state goes to `ST_IDLE`. `PEND` still sets.
- `RESET` mid-count: next edge returns everything to reset values, and pending interrupts are dropped.
- `IN_PORT` has zero-cycle latency: the same cycle `PORT_ID` is presented, matching the CPU IN execute cycle.
- `SNAP` is valid on the cycle after the `SNAP_LO` write.

## Structure
- Package `rat_io_pkg` holds:
  - Offset constants `OFS_CTRL`..`OFS_PRESCALE`.
  - `CTRL`/`STATUS` bit-index constants.
  - The `timer_state_t` enum (`ST_IDLE`, `ST_LOAD`, `ST_RUN`, `ST_DONE`).
  - It is shared with future RAT I/O peripherals.
- One sub-module is natural: `timer_prescaler` owns `pre`, reloads to P, and outputs a one-cycle `tick` when `pre`==0 in `ST_RUN`.
- Register file, address decode, FSM and `count` stay in `rat_timer_io`.

## Test plan
- Reset, then sweep reads of IDs 8'hB0..8'hB6 plus 8'h00 → all `IN_PORT`=8'h00 and `INT`=0.
- Configure R=3, P=1, `CTRL`=8'h05 (`EN`+`IRQ_EN`):
  - `RUNNING`=1 until expiry.
  - `INT` rises exactly 10 edges after the `CTRL` write (1 load + 8 run + 1).
  - State then sits in `ST_DONE` with `RUNNING`=0.
- Auto-reload with R=0, P=0, `CTRL`=8'h07 → expiry every 2 cycles.
  - Write 8'h01 to `STATUS` on an expiry cycle → `PEND` remains 1 (set wins).
- Running with R=16'h1234, P=0: write `SNAP_LO` at a known cycle → `SNAP` equals the expected live count, read back correctly via +4/+5.
- Write `CTRL`=8'h00 mid-run → `ST_IDLE`, count frozen, no further `PEND`.
  - Writing `CTRL`=8'h01 afterwards reloads from R.
- Assert `RESET` during `ST_RUN` with `PEND`=1 → next cycle `INT`=0, all registers read 0.
- Write to unmapped 8'hB7 → no register changes.
